// File: rtl/wash_pkg.sv
// Shared definitions for the washing-machine cycle sequencer: state codes,
// actuator bit positions and the quick-mode duration helper.
package wash_pkg;

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_FILL        = 4'd1,
    S_WASH        = 4'd2,
    S_DRAIN       = 4'd3,
    S_RINSE_FILL  = 4'd4,
    S_RINSE       = 4'd5,
    S_RINSE_DRAIN = 4'd6,
    S_SPIN        = 4'd7,
    S_DONE        = 4'd8,
    S_ABORT_DRAIN = 4'd9
  } state_t;

  localparam int ACT_FILL  = 0;
  localparam int ACT_AGIT  = 1;
  localparam int ACT_MOTOR = 2;
  localparam int ACT_PUMP  = 3;
  localparam int ACT_SPEED = 4;
  localparam int ACT_W     = 5;

  // Quick mode halves a phase but never shortens it below one cycle.
  function automatic int half_len(input int cyc);
    return ((cyc >> 1) < 1) ? 1 : (cyc >> 1);
  endfunction

endpackage

// File: rtl/wash_phase_timer.sv
// Phase duration down-counter: loads on phase entry, counts while enabled,
// and holds at zero so expiry stays visible until the next load.
module wash_phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign expired = (count_reg == '0);

endmodule

// File: rtl/wash_cycle_sequencer.sv
// Self-timed washing-machine controller: fill/wash/drain, N rinse passes,
// spin, with door pause and abort-with-drain. Actuators decode from state.
module wash_cycle_sequencer
  import wash_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int FILL_CYC  = 4,
  parameter int WASH_CYC  = 6,
  parameter int DRAIN_CYC = 3,
  parameter int RINSE_CYC = 5,
  parameter int SPIN_CYC  = 8,
  parameter int RINSE_N   = 2,
  parameter int RC_W      = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            door,
  input  logic            quick,
  output logic            water_fill,
  output logic            agitator,
  output logic            motor,
  output logic            pump,
  output logic            speed,
  output logic            busy,
  output logic            paused,
  output logic            done,
  output logic            aborted,
  output logic [RC_W-1:0] rinse_cnt,
  output logic [3:0]      state
);

  localparam logic [CNT_W-1:0] FILL_LD    = CNT_W'(FILL_CYC - 1);
  localparam logic [CNT_W-1:0] WASH_LD    = CNT_W'(WASH_CYC - 1);
  localparam logic [CNT_W-1:0] WASH_Q_LD  = CNT_W'(half_len(WASH_CYC) - 1);
  localparam logic [CNT_W-1:0] DRAIN_LD   = CNT_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] RINSE_LD   = CNT_W'(RINSE_CYC - 1);
  localparam logic [CNT_W-1:0] RINSE_Q_LD = CNT_W'(half_len(RINSE_CYC) - 1);
  localparam logic [CNT_W-1:0] SPIN_LD    = CNT_W'(SPIN_CYC - 1);
  localparam logic [RC_W:0]    RINSE_LIM  = (RC_W + 1)'(RINSE_N);

  state_t            state_reg, state_next;
  logic [RC_W-1:0]   rinse_cnt_reg, rinse_cnt_next;
  logic              quick_reg, quick_next;
  logic              aborted_reg, aborted_next;
  logic              door_reg;
  logic              tmr_load, tmr_expired;
  logic [CNT_W-1:0]  tmr_load_val;
  logic              active, pause_act, adv;
  logic [RC_W:0]     rinse_inc;
  logic [ACT_W-1:0]  act;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      rinse_cnt_reg <= '0;
      quick_reg     <= 1'b0;
      aborted_reg   <= 1'b0;
      door_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rinse_cnt_reg <= rinse_cnt_next;
      quick_reg     <= quick_next;
      aborted_reg   <= aborted_next;
      door_reg      <= door;
    end
  end

  wash_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .en       (!pause_act),
    .expired  (tmr_expired)
  );

  assign active    = (state_reg >= S_FILL) && (state_reg <= S_SPIN);
  assign pause_act = door_reg && active;
  assign adv       = tmr_expired && !pause_act && !abort;
  assign rinse_inc = {1'b0, rinse_cnt_reg} + 1'b1;

  always_comb begin
    state_next     = state_reg;
    rinse_cnt_next = rinse_cnt_reg;
    quick_next     = quick_reg;
    aborted_next   = 1'b0;
    tmr_load       = 1'b0;
    tmr_load_val   = '0;
    case (state_reg)
      S_IDLE: if (start && !door && !abort) begin
        state_next     = S_FILL;
        tmr_load       = 1'b1;
        tmr_load_val   = FILL_LD;
        quick_next     = quick;
        rinse_cnt_next = '0;
      end
      S_FILL: if (adv) begin
        state_next   = S_WASH;
        tmr_load     = 1'b1;
        tmr_load_val = quick_reg ? WASH_Q_LD : WASH_LD;
      end
      S_WASH: if (adv) begin
        state_next   = S_DRAIN;
        tmr_load     = 1'b1;
        tmr_load_val = DRAIN_LD;
      end
      S_DRAIN: if (adv) begin
        tmr_load = 1'b1;
        if (RINSE_N == 0) begin
          state_next   = S_SPIN;
          tmr_load_val = SPIN_LD;
        end else begin
          state_next   = S_RINSE_FILL;
          tmr_load_val = FILL_LD;
        end
      end
      S_RINSE_FILL: if (adv) begin
        state_next   = S_RINSE;
        tmr_load     = 1'b1;
        tmr_load_val = quick_reg ? RINSE_Q_LD : RINSE_LD;
      end
      S_RINSE: if (adv) begin
        state_next   = S_RINSE_DRAIN;
        tmr_load     = 1'b1;
        tmr_load_val = DRAIN_LD;
      end
      S_RINSE_DRAIN: if (adv) begin
        rinse_cnt_next = rinse_inc[RC_W-1:0];
        tmr_load       = 1'b1;
        if (rinse_inc < RINSE_LIM) begin
          state_next   = S_RINSE_FILL;
          tmr_load_val = FILL_LD;
        end else begin
          state_next   = S_SPIN;
          tmr_load_val = SPIN_LD;
        end
      end
      S_SPIN: if (adv) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      S_ABORT_DRAIN: if (tmr_expired) begin
        state_next   = S_IDLE;
        aborted_next = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
    // Abort overrides everything, including a pause and a same-cycle expiry.
    if (active && abort) begin
      state_next   = S_ABORT_DRAIN;
      tmr_load     = 1'b1;
      tmr_load_val = DRAIN_LD;
    end
  end

  always_comb begin
    act = '0;
    case (state_reg)
      S_FILL, S_RINSE_FILL:                  act[ACT_FILL] = 1'b1;
      S_WASH, S_RINSE: begin
        act[ACT_AGIT]  = 1'b1;
        act[ACT_MOTOR] = 1'b1;
      end
      S_DRAIN, S_RINSE_DRAIN, S_ABORT_DRAIN: act[ACT_PUMP] = 1'b1;
      S_SPIN: begin
        act[ACT_PUMP]  = 1'b1;
        act[ACT_MOTOR] = 1'b1;
        act[ACT_SPEED] = 1'b1;
      end
      default: ;
    endcase
    if (pause_act) act = '0;
  end

  assign water_fill = act[ACT_FILL];
  assign agitator   = act[ACT_AGIT];
  assign motor      = act[ACT_MOTOR];
  assign pump       = act[ACT_PUMP];
  assign speed      = act[ACT_SPEED];
  assign busy       = (state_reg != S_IDLE);
  assign paused     = pause_act;
  assign done       = (state_reg == S_DONE);
  assign aborted    = aborted_reg;
  assign rinse_cnt  = rinse_cnt_reg;
  assign state      = state_reg;

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Directed bench: timeline table of input segments with expected state and
// outputs per cycle, plus hand sequences for async reset and RINSE_N=0.
module tb_wash_cycle_sequencer;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  localparam logic [3:0] ST_IDLE = 4'd0, ST_FILL = 4'd1, ST_WASH = 4'd2, ST_DRAIN = 4'd3;
  localparam logic [3:0] ST_RF = 4'd4, ST_RINSE = 4'd5, ST_RD = 4'd6, ST_SPIN = 4'd7;
  localparam logic [3:0] ST_DONE = 4'd8, ST_ABORT = 4'd9;

  // {water_fill, agitator, motor, pump, speed, busy, paused, done, aborted}
  localparam logic [8:0] O_IDLE  = 9'b000000000;
  localparam logic [8:0] O_FILL  = 9'b100001000;
  localparam logic [8:0] O_WASH  = 9'b011001000;
  localparam logic [8:0] O_DRN   = 9'b000101000;
  localparam logic [8:0] O_SPIN  = 9'b001111000;
  localparam logic [8:0] O_DONE  = 9'b000001010;
  localparam logic [8:0] O_PAUSE = 9'b000001100;
  localparam logic [8:0] O_ABTD  = 9'b000000001;

  typedef struct {
    logic       start, door, abort, quick;
    int         n;
    logic [3:0] st;
    logic [8:0] outs;
    logic [2:0] rc;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, start, abort, door, quick;
  logic water_fill, agitator, motor, pump, speed, busy, paused, done, aborted;
  logic [2:0] rinse_cnt;
  logic [3:0] state;
  logic water_fill0, agitator0, motor0, pump0, speed0, busy0, paused0, done0, aborted0;
  logic [2:0] rinse_cnt0;
  logic [3:0] state0;
  logic [8:0] outs, outs0;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  wash_cycle_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .door(door), .quick(quick),
    .water_fill(water_fill), .agitator(agitator), .motor(motor), .pump(pump), .speed(speed),
    .busy(busy), .paused(paused), .done(done), .aborted(aborted),
    .rinse_cnt(rinse_cnt), .state(state)
  );

  wash_cycle_sequencer #(.RINSE_N(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .door(door), .quick(quick),
    .water_fill(water_fill0), .agitator(agitator0), .motor(motor0), .pump(pump0), .speed(speed0),
    .busy(busy0), .paused(paused0), .done(done0), .aborted(aborted0),
    .rinse_cnt(rinse_cnt0), .state(state0)
  );

  assign outs  = {water_fill, agitator, motor, pump, speed, busy, paused, done, aborted};
  assign outs0 = {water_fill0, agitator0, motor0, pump0, speed0, busy0, paused0, done0, aborted0};

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add(input logic s, input logic d, input logic a, input logic q, input int n,
                     input logic [3:0] st, input logic [8:0] o, input logic [2:0] rc);
    vec_t v;
    v.start = s; v.door = d; v.abort = a; v.quick = q;
    v.n = n; v.st = st; v.outs = o; v.rc = rc;
    vecs.push_back(v);
  endtask

  // Two full rinse passes, spin, done and a short idle tail.
  task automatic add_tail(input int rlen);
    add(L, L, L, L, 4,    ST_RF,    O_FILL, 3'd0);
    add(L, L, L, L, rlen, ST_RINSE, O_WASH, 3'd0);
    add(L, L, L, L, 3,    ST_RD,    O_DRN,  3'd0);
    add(L, L, L, L, 4,    ST_RF,    O_FILL, 3'd1);
    add(L, L, L, L, rlen, ST_RINSE, O_WASH, 3'd1);
    add(L, L, L, L, 3,    ST_RD,    O_DRN,  3'd1);
    add(L, L, L, L, 8,    ST_SPIN,  O_SPIN, 3'd2);
    add(L, L, L, L, 1,    ST_DONE,  O_DONE, 3'd2);
    add(L, L, L, L, 2,    ST_IDLE,  O_IDLE, 3'd2);
  endtask

  initial begin
    logic [3:0] exp_st;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; door = 1'b0; quick = 1'b0;
    #1;
    check("reset_dut",  {state, outs, rinse_cnt},    16'h0);
    check("reset_dut0", {state0, outs0, rinse_cnt0}, 16'h0);

    // Default full cycle: done at cycle 46.
    add(H, L, L, L, 1, ST_FILL,  O_FILL, 3'd0);
    add(L, L, L, L, 3, ST_FILL,  O_FILL, 3'd0);
    add(L, L, L, L, 6, ST_WASH,  O_WASH, 3'd0);
    add(L, L, L, L, 3, ST_DRAIN, O_DRN,  3'd0);
    add_tail(5);
    // Quick mode latched at start, toggled afterwards: done at cycle 37.
    add(H, L, L, H, 1, ST_FILL,  O_FILL, 3'd0);
    add(L, L, L, L, 3, ST_FILL,  O_FILL, 3'd0);
    add(L, L, L, H, 3, ST_WASH,  O_WASH, 3'd0);
    add(L, L, L, L, 3, ST_DRAIN, O_DRN,  3'd0);
    add_tail(2);
    // Door open for three cycles in WASH: done at cycle 49.
    add(H, L, L, L, 1, ST_FILL,  O_FILL,  3'd0);
    add(L, L, L, L, 3, ST_FILL,  O_FILL,  3'd0);
    add(L, L, L, L, 2, ST_WASH,  O_WASH,  3'd0);
    add(L, H, L, L, 3, ST_WASH,  O_PAUSE, 3'd0);
    add(L, L, L, L, 4, ST_WASH,  O_WASH,  3'd0);
    add(L, L, L, L, 3, ST_DRAIN, O_DRN,   3'd0);
    add_tail(5);
    // Abort during the second RINSE; abort drain ignores door and abort.
    add(H, L, L, L, 1, ST_FILL,  O_FILL, 3'd0);
    add(L, L, L, L, 3, ST_FILL,  O_FILL, 3'd0);
    add(L, L, L, L, 6, ST_WASH,  O_WASH, 3'd0);
    add(L, L, L, L, 3, ST_DRAIN, O_DRN,  3'd0);
    add(L, L, L, L, 4, ST_RF,    O_FILL, 3'd0);
    add(L, L, L, L, 5, ST_RINSE, O_WASH, 3'd0);
    add(L, L, L, L, 3, ST_RD,    O_DRN,  3'd0);
    add(L, L, L, L, 4, ST_RF,    O_FILL, 3'd1);
    add(L, L, L, L, 2, ST_RINSE, O_WASH, 3'd1);
    add(L, L, H, L, 1, ST_ABORT, O_DRN,  3'd1);
    add(L, H, H, L, 2, ST_ABORT, O_DRN,  3'd1);
    add(L, L, L, L, 1, ST_IDLE,  O_ABTD, 3'd1);
    add(L, L, L, L, 2, ST_IDLE,  O_IDLE, 3'd1);
    // Start with door open, then with abort high: both ignored.
    add(H, H, L, L, 2, ST_IDLE,  O_IDLE, 3'd1);
    add(L, L, L, L, 1, ST_IDLE,  O_IDLE, 3'd1);
    add(H, L, H, L, 2, ST_IDLE,  O_IDLE, 3'd1);
    add(L, L, L, L, 1, ST_IDLE,  O_IDLE, 3'd1);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        start = vecs[i].start; door = vecs[i].door;
        abort = vecs[i].abort; quick = vecs[i].quick;
        @(posedge clk);
        #1;
        check($sformatf("vec%0d_c%0d", i, k), {state, outs, rinse_cnt},
              {vecs[i].st, vecs[i].outs, vecs[i].rc});
      end
      $display("seg %0d: n=%0d state=%0d outs=%b rinse_cnt=%0d",
               i, vecs[i].n, state, outs, rinse_cnt);
    end
    start = 1'b0; door = 1'b0; abort = 1'b0; quick = 1'b0;

    // Reset asserted mid-SPIN clears outputs without waiting for a clock.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (37) @(posedge clk);
    #1;
    check("spin_before_reset", {11'd0, state, speed}, {11'd0, ST_SPIN, 1'b1});
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_dut",  {state, outs, rinse_cnt},    16'h0);
    check("async_reset_dut0", {state0, outs0, rinse_cnt0}, 16'h0);
    $display("async reset: state=%0d outs=%b", state, outs);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("post_reset_idle%0d", k), {11'd0, state, busy}, 16'h0);
    end

    // RINSE_N=0 build: DRAIN goes straight to SPIN, done at cycle 22.
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (cyc <= 4)       exp_st = ST_FILL;
      else if (cyc <= 10) exp_st = ST_WASH;
      else if (cyc <= 13) exp_st = ST_DRAIN;
      else if (cyc <= 21) exp_st = ST_SPIN;
      else if (cyc == 22) exp_st = ST_DONE;
      else                exp_st = ST_IDLE;
      check($sformatf("rn0_c%0d", cyc), {10'd0, state0, done0, busy0},
            {10'd0, exp_st, (cyc == 22), (cyc <= 22)});
      if (cyc == 1) check("restart_dut", {12'd0, state}, {12'd0, ST_FILL});
      $display("rinse_n0 cycle %0d: state=%0d done=%0d", cyc, state0, done0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wash_cycle_sequencer.md
Name: wash_cycle_sequencer

Overview:
Parametrised, self-timed washing-machine cycle controller. It replaces externally supplied phase-timer strobes with an internal down-counter. It adds a configurable rinse count, a quick mode, door-open pause/resume and an abort-with-drain path. It sits between the front-panel inputs (start, abort, door, quick) and the actuator drivers (valve, agitator, motor, pump, spin speed).

Parameters:
CNT_W, 16, width of phase timer.
FILL_CYC, 4, cycles in FILL and RINSE_FILL (≥1).
WASH_CYC, 6, cycles in WASH (≥1).
DRAIN_CYC, 3, cycles in DRAIN, RINSE_DRAIN and ABORT_DRAIN (≥1).
RINSE_CYC, 5, cycles in RINSE (≥1).
SPIN_CYC, 8, cycles in SPIN (≥1).
RINSE_N, 2, rinse passes (0..2^RC_W-1); 0 skips rinse.
RC_W, 3, width of rinse counter.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  level; sampled each cycle in IDLE
abort  in  1  level; sampled each cycle in any active state
door  in  1  1 = door open
quick  in  1  latched at accepted start; halves WASH/RINSE
water_fill  out  1  inlet valve
agitator  out  1  agitator drive
motor  out  1  drum motor
pump  out  1  drain pump
speed  out  1  1 = high spin speed
busy  out  1  state ≠ IDLE
paused  out  1  door-pause active
done  out  1  one-cycle pulse, cycle completed
aborted  out  1  one-cycle pulse, abort drain finished
rinse_cnt  out  RC_W  completed rinse passes in current cycle
state  out  4  current state code

Behaviour:
- Reset (async assert, sync release): state=IDLE, timer=0, rinse_cnt=0, quick_q=0, door_q=0. All outputs 0.
- door is registered into door_q; paused = door_q and state in {FILL..SPIN}.
- Phase order: IDLE → FILL → WASH → DRAIN → [RINSE_FILL → RINSE → RINSE_DRAIN] ×RINSE_N → SPIN → DONE → IDLE.
- Abort path: any of FILL..SPIN → ABORT_DRAIN → IDLE.
- IDLE: start=1 and door=0 and abort=0 at an edge → FILL.
  - Timer loads FILL_CYC-1, quick_q←quick, rinse_cnt←0.
  - Start with door open, or with abort high, is ignored.
  - Start while busy is ignored.
- Each phase entry loads timer with its duration-1. Quick_q=1 uses max(WASH_CYC>>1,1) and max(RINSE_CYC>>1,1).
- Timer decrements each unpaused cycle. Timer=0 and not paused → next phase, so each phase lasts exactly N unpaused cycles.
- RINSE_DRAIN exit: rinse_cnt increments. If the new count < RINSE_N go to RINSE_FILL, else go to SPIN. RINSE_N=0: DRAIN → SPIN directly.
- Moore outputs, decoded from registered state; all forced 0 while paused:
  - FILL, RINSE_FILL: water_fill.
  - WASH, RINSE: agitator, motor.
  - DRAIN, RINSE_DRAIN, ABORT_DRAIN: pump.
  - SPIN: pump, motor, speed.
  - DONE: done=1 for exactly one cycle.
- Pause: state and timer frozen while paused. Resume the cycle after door_q falls. Total cycle time grows by exactly the number of paused cycles.
- Abort=1 in FILL..SPIN (paused or not) → ABORT_DRAIN, timer←DRAIN_CYC-1.
  - ABORT_DRAIN ignores door and runs to completion.
  - Then aborted=1 for one cycle and state → IDLE. done is not asserted.
- Abort in DONE or ABORT_DRAIN is ignored.
- Simultaneous abort and timer expiry: abort wins.
- Reset mid-operation: immediate return to reset values; no drain is performed.
- State codes, 4 bits: IDLE=0, FILL=1, WASH=2, DRAIN=3, RINSE_FILL=4, RINSE=5, RINSE_DRAIN=6, SPIN=7, DONE=8, ABORT_DRAIN=9. Unused codes → IDLE.

Decomposition:
- Package wash_pkg: state encoding constants, actuator-bit index constants.
- Sub-module wash_phase_timer:
  - Inputs: load, load_val[CNT_W], en.
  - Output: expired.
  - Down-counter holding at 0.
  - Instantiated once; the FSM drives load on every phase entry and en = !paused.

Test Plan:
- Default params, start pulse at edge 0, door=0, quick=0 → FILL cycles 1–4, WASH 5–10, DRAIN 11–13, rinse passes 14–37 (rinse_cnt 1 at 26, 2 at 38), SPIN 38–45 with speed=1, done=1 only at cycle 46, busy=0 from 47.
- Same with quick=1 latched at start → WASH 3 cycles, RINSE 2 cycles, done at cycle 37; toggling quick mid-cycle has no effect.
- door=1 for 3 cycles during WASH → the cycle after door rises all actuators 0, paused=1; timer frozen; done at cycle 49.
- abort=1 for one cycle during RINSE → ABORT_DRAIN next cycle, pump=1 for 3 cycles, then aborted pulse, IDLE, done never asserted, rinse_cnt holds its value.
- start with door=1 in IDLE → stays IDLE, busy=0. start with abort=1 → stays IDLE. RINSE_N=0 build → DRAIN goes straight to SPIN, done at cycle 22.
- rst_n low mid-SPIN → all outputs 0 asynchronously. After release, stays IDLE until the next start.
